x3q16_spi_mem: RTL and testbench

//  Memory-side stage below the x3q16 core. Takes the core's single-cycle

---
 rtl/x3q16_spi_mem.sv | 185 ++++++++++++++++++
 tb/tb_x3q16_spi_mem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x3q16_spi_mem.sv
// Runs one x3q16 core read/write request as a single 40-bit SPI mode-0 frame
// on a 23LC512-class serial SRAM: {opcode, byte address, 16-bit data word}.
module x3q16_spi_mem #(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request,
    input  logic        request_type,
    input  logic [15:0] request_address,
    input  logic [15:0] data_out,
    output logic [15:0] memory_in,
    output logic        memory_ready,
    output logic        write_complete,
    output logic        busy,
    output logic        req_dropped,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]      LAST_BIT = 6'd39;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [39:0]      tx_r;
    logic [15:0]      rx_r;
    logic [5:0]       bit_cnt_r;
    logic [DIV_W-1:0] div_r;
    logic             is_write_r;
    logic [15:0]      memory_in_r;
    logic             ready_r;
    logic             write_done_r;
    logic             busy_r;
    logic             dropped_r;
    logic             cs_n_r;
    logic             sclk_r;
    logic             mosi_r;

    logic             div_tc_s;
    logic             accept_s;
    logic             rise_s;
    logic             fall_s;
    logic             last_s;
    logic             finish_s;
    logic [39:0]      tx_load_s;
    // The SRAM is byte addressed; word address bit 15 has no place in a 16-bit byte address.
    logic             unused_addr_msb_s;

    assign unused_addr_msb_s = request_address[15];
    assign div_tc_s          = (div_r == DIV_LAST);
    assign tx_load_s         = {(request_type ? CMD_WRITE : CMD_READ),
                                request_address[14:0], 1'b0,
                                (request_type ? data_out : 16'h0000)};

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        last_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (request) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_tc_s) begin
                    if (sclk_r == 1'b0) begin
                        rise_s       = 1'b1;
                        state_next_s = ST_SHIFT;
                    end else begin
                        fall_s = 1'b1;
                        if (bit_cnt_r == LAST_BIT) begin
                            last_s       = 1'b1;
                            state_next_s = ST_FINISH;
                        end else begin
                            state_next_s = ST_SHIFT;
                        end
                    end
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                finish_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, SPI shift datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            tx_r         <= 40'h00_0000_0000;
            rx_r         <= 16'h0000;
            bit_cnt_r    <= 6'd0;
            div_r        <= '0;
            is_write_r   <= 1'b0;
            memory_in_r  <= 16'h0000;
            ready_r      <= 1'b0;
            write_done_r <= 1'b0;
            busy_r       <= 1'b0;
            dropped_r    <= 1'b0;
            cs_n_r       <= 1'b1;
            sclk_r       <= 1'b0;
            mosi_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ready_r      <= 1'b0;
            write_done_r <= 1'b0;
            if (request && (state_r != ST_IDLE)) begin
                dropped_r <= 1'b1;
            end
            if (accept_s) begin
                tx_r       <= tx_load_s;
                is_write_r <= request_type;
                cs_n_r     <= 1'b0;
                sclk_r     <= 1'b0;
                mosi_r     <= tx_load_s[39];
                bit_cnt_r  <= 6'd0;
                div_r      <= '0;
                busy_r     <= 1'b1;
            end
            if (state_r == ST_SHIFT) begin
                div_r <= div_tc_s ? '0 : (div_r + DIV_W'(1));
            end
            if (rise_s) begin
                sclk_r <= 1'b1;
                rx_r   <= {rx_r[14:0], spi_miso};
            end
            // tx_r shifts left so the next bit to send always sits at [38].
            if (fall_s) begin
                sclk_r <= 1'b0;
                if (last_s) begin
                    cs_n_r <= 1'b1;
                end else begin
                    mosi_r    <= tx_r[38];
                    tx_r      <= {tx_r[38:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                end
            end
            if (finish_s) begin
                busy_r <= 1'b0;
                if (is_write_r) begin
                    write_done_r <= 1'b1;
                end else begin
                    memory_in_r <= rx_r;
                    ready_r     <= 1'b1;
                end
            end
        end
    end

    assign memory_in      = memory_in_r;
    assign memory_ready   = ready_r;
    assign write_complete = write_done_r;
    assign busy           = busy_r;
    assign req_dropped    = dropped_r;
    assign spi_cs_n       = cs_n_r;
    assign spi_sclk       = sclk_r;
    assign spi_mosi       = mosi_r;

endmodule

// File: tb/tb_x3q16_spi_mem.sv
// Directed bench for x3q16_spi_mem: CLK_DIV=1 unit against a behavioural
// serial SRAM, plus a CLK_DIV=3 unit for divider timing.
module tb_x3q16_spi_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        request, request_type;
    logic [15:0] request_address, data_out;
    logic [15:0] memory_in;
    logic        memory_ready, write_complete, busy, req_dropped;
    logic        spi_cs_n, spi_sclk, spi_mosi;
    logic        miso_m = 1'b0;

    logic        request3;
    logic [15:0] memory_in3;
    logic        memory_ready3, write_complete3, busy3, req_dropped3;
    logic        spi_cs_n3, spi_sclk3, spi_mosi3;

    x3q16_spi_mem #(.CLK_DIV(1)) dut (
        .clk(clk), .reset(reset), .request(request), .request_type(request_type),
        .request_address(request_address), .data_out(data_out),
        .memory_in(memory_in), .memory_ready(memory_ready),
        .write_complete(write_complete), .busy(busy), .req_dropped(req_dropped),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(miso_m)
    );

    x3q16_spi_mem #(.CLK_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .request(request3), .request_type(1'b0),
        .request_address(16'h0001), .data_out(16'h0000),
        .memory_in(memory_in3), .memory_ready(memory_ready3),
        .write_complete(write_complete3), .busy(busy3), .req_dropped(req_dropped3),
        .spi_cs_n(spi_cs_n3), .spi_sclk(spi_sclk3), .spi_mosi(spi_mosi3),
        .spi_miso(1'b1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural 23LC512-style SRAM, word-organised, mode 0.
    logic [15:0] mem [0:32767];
    int          n_bits = 0;
    logic [39:0] sh = '0;
    logic [39:0] last_frame = '0;
    logic [7:0]  cmd_m = '0;
    logic [15:0] addr_m = '0;
    int          frames = 0;

    always @(negedge spi_cs_n) begin
        n_bits = 0;
        sh     = '0;
        miso_m = 1'b0;
        frames++;
    end

    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            sh = {sh[38:0], spi_mosi};
            n_bits++;
            if (n_bits == 24) begin
                cmd_m  = sh[23:16];
                addr_m = sh[15:0];
            end
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n && n_bits >= 24 && n_bits < 40 && cmd_m == 8'h03)
            miso_m = mem[addr_m[15:1]][39 - n_bits];
    end

    always @(posedge spi_cs_n) begin
        last_frame = sh;
        if (n_bits == 40 && sh[39:32] == 8'h02)
            mem[sh[31:17]] = sh[15:0];
    end

    int ready_cnt = 0, wc_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (memory_ready) ready_cnt++;
        if (write_complete) wc_cnt++;
        if (memory_ready && write_complete) both_cnt++;
    end

    task automatic do_req(input logic typ, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat);
        @(negedge clk);
        request = 1'b1; request_type = typ; request_address = addr; data_out = wd;
        @(posedge clk); #1;
        request = 1'b0; request_type = ~typ; request_address = ~addr; data_out = ~wd;
        check_value("busy_on_accept", 40'(busy), 40'd1);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (memory_ready || write_complete) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        check_value("pulse_width", 40'({memory_ready, write_complete, busy}), 40'd0);
    endtask

    int lat, f0, r0, w0, pulses, gap, min_gap, rise1, rise2;
    logic started, prev3, prev_sclk;
    int tog;

    initial begin
        request = 1'b0; request_type = 1'b0; request_address = 16'h0000; data_out = 16'h0000;
        request3 = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0000] = 16'hA5C3;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_cs_n", 40'(spi_cs_n), 40'd1);
        check_value("rst_sclk", 40'(spi_sclk), 40'd0);
        check_value("rst_mosi", 40'(spi_mosi), 40'd0);
        check_value("rst_memory_in", 40'(memory_in), 40'd0);
        check_value("rst_pulses", 40'({memory_ready, write_complete}), 40'd0);
        check_value("rst_busy_drop", 40'({busy, req_dropped}), 40'd0);
        @(negedge clk) reset = 1'b1;

        do_req(1'b0, 16'h0010, 16'h1111, lat);
        check_value("rd_latency", 40'(lat), 40'd81);
        check_value("rd_data", 40'(memory_in), 40'h00_0000_BEEF);
        check_value("rd_frame", 40'(last_frame[39:16]), 40'h03_0020);

        do_req(1'b1, 16'h7FFF, 16'h1234, lat);
        check_value("wr_latency", 40'(lat), 40'd81);
        check_value("wr_frame", last_frame, 40'h02_FFFE_1234);
        check_value("wr_holds_mem_in", 40'(memory_in), 40'h00_0000_BEEF);
        do_req(1'b0, 16'h7FFF, 16'h0000, lat);
        check_value("rdback_data", 40'(memory_in), 40'h00_0000_1234);
        check_value("rdback_frame", 40'(last_frame[39:16]), 40'h03_FFFE);

        do_req(1'b1, 16'h8005, 16'h5A5A, lat);
        check_value("wrap_wr_frame", last_frame, 40'h02_000A_5A5A);
        do_req(1'b0, 16'h0005, 16'h0000, lat);
        check_value("wrap_rd_data", 40'(memory_in), 40'h00_0000_5A5A);
        check_value("no_drop_yet", 40'(req_dropped), 40'd0);

        // Drop: second request arrives mid-frame.
        @(negedge clk);
        request = 1'b1; request_type = 1'b0; request_address = 16'h0010;
        @(posedge clk); #1;
        request = 1'b0;
        f0 = frames; w0 = wc_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        request = 1'b1; request_type = 1'b1; request_address = 16'h0020; data_out = 16'hDEAD;
        @(negedge clk);
        request = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (memory_ready) begin lat = i; break; end
        end
        repeat (100) @(posedge clk);
        #1;
        check_value("drop_got_pulse", 40'(lat >= 0), 40'd1);
        check_value("drop_frames", 40'(frames - f0), 40'd0);
        check_value("drop_flag", 40'(req_dropped), 40'd1);
        check_value("drop_result", 40'(memory_in), 40'h00_0000_BEEF);
        check_value("drop_no_write", 40'(wc_cnt - w0), 40'd0);

        // Reset in the middle of a frame, at SCLK edge 20.
        @(negedge clk);
        request = 1'b1; request_type = 1'b0; request_address = 16'h0010;
        @(posedge clk); #1;
        request = 1'b0;
        tog = 0; prev_sclk = spi_sclk;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (spi_sclk != prev_sclk) tog++;
            prev_sclk = spi_sclk;
            if (tog == 20) break;
        end
        check_value("rst_mid_edges", 40'(tog), 40'd20);
        r0 = ready_cnt; w0 = wc_cnt;
        #2;
        reset = 1'b0; request = 1'b1; request_address = 16'h0000;
        #1;
        check_value("abort_cs_sclk", 40'({spi_cs_n, spi_sclk}), 40'b10);
        check_value("abort_state", 40'({busy, req_dropped, memory_ready, write_complete}), 40'd0);
        check_value("abort_mem_in", 40'(memory_in), 40'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        request = 1'b0;
        check_value("rel_accept", 40'({busy, spi_cs_n}), 40'b10);
        check_value("abort_no_pulse", 40'((ready_cnt - r0) + (wc_cnt - w0)), 40'd0);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (memory_ready) begin lat = i; break; end
        end
        check_value("rel_latency", 40'(lat), 40'd81);
        check_value("rel_data", 40'(memory_in), 40'h00_0000_A5C3);
        check_value("rel_frame", 40'(last_frame[39:16]), 40'h03_0000);

        // Back-to-back reads with request held high.
        @(negedge clk);
        request = 1'b1; request_type = 1'b0; request_address = 16'h0010;
        f0 = frames; pulses = 0; gap = 0; min_gap = 999; started = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (frames - f0 >= 3) request = 1'b0;
            if (memory_ready) pulses++;
            if (!spi_cs_n) begin
                if (started && gap > 0 && gap < min_gap) min_gap = gap;
                started = 1'b1;
                gap = 0;
            end else if (started) begin
                gap++;
            end
            if (pulses == 3) break;
        end
        request = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("b2b_frames", 40'(frames - f0), 40'd3);
        check_value("b2b_pulses", 40'(pulses), 40'd3);
        check_value("b2b_gap", 40'(min_gap), 40'd2);
        check_value("b2b_data", 40'(memory_in), 40'h00_0000_BEEF);

        // CLK_DIV=3 unit: SCLK period and completion latency.
        @(negedge clk) request3 = 1'b1;
        @(posedge clk); #1;
        request3 = 1'b0;
        lat = -1; rise1 = -1; rise2 = -1; prev3 = spi_sclk3;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (spi_sclk3 && !prev3) begin
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            prev3 = spi_sclk3;
            if (memory_ready3) begin lat = i; break; end
        end
        check_value("div3_latency", 40'(lat), 40'd241);
        check_value("div3_period", 40'(rise2 - rise1), 40'd6);
        check_value("div3_data", 40'(memory_in3), 40'h00_0000_FFFF);
        check_value("pulses_exclusive", 40'(both_cnt), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
